// File: rtl/act_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// act_skew_feeder_pkg
// Shared definitions for the activation skew feeder: the feeder FSM state
// encoding, default array geometry, and the helpers used to slice the packed
// per-lane activation buses.
// ---------------------------------------------------------------------------
package act_skew_feeder_pkg;

  // Feeder control states: waiting for a tile, accepting vectors, draining
  // the skew so the last vector reaches the bottom lane.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } feeder_state_e;

  localparam int ROWS_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int LEN_W_DEF = 8;

  // The flush counter only ever holds ROWS-1, which is at most 15.
  localparam int ROWS_MAX = 16;
  localparam int FLUSH_W  = $clog2(ROWS_MAX);

  // Lowest bit of lane 'lane' inside a packed ROWS*DW activation bus.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/act_skew_feeder_skew_delay_line.sv
// ---------------------------------------------------------------------------
// skew_delay_line
// Fixed-length shift register carrying one activation lane plus its valid
// flag. A sample entering on data_i/valid_i appears on data_o/valid_o exactly
// DEPTH rising edges later.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset, clears every stage
//   data_i   - lane data entering the line
//   valid_i  - lane valid entering the line
//   data_o   - lane data leaving the last stage
//   valid_o  - lane valid leaving the last stage
// ---------------------------------------------------------------------------
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);

  logic [DW-1:0] data_q  [DEPTH];
  logic          valid_q [DEPTH];

  // Stage 0 captures the lane input, every later stage takes its predecessor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// ---------------------------------------------------------------------------
// act_skew_feeder
// Accepts a tile of activation vectors and presents them to the west edge of
// a systolic array with the diagonal skew the array needs: lane r of a vector
// appears r+1 cycles after the vector was accepted. After the last vector the
// feeder flushes ROWS-1 cycles of zeros and pulses tile_done exactly when the
// bottom lane shows the tile's final element.
//
// Ports:
//   clk            - clock, rising edge
//   reset_n        - asynchronous active-low reset
//   start          - begin a tile (honoured only while idle)
//   tile_len       - number of vectors in the tile, latched with start
//   in_valid       - upstream vector valid
//   in_ready       - feeder accepts a vector this cycle (streaming only)
//   in_data        - one activation per lane, lane r at [r*DW +: DW]
//   out_west       - skewed activations to the array west edge
//   out_lane_valid - per-lane flag, lane carries a real element
//   busy           - tile in progress (streaming or flushing)
//   tile_done      - one-cycle completion pulse
// ---------------------------------------------------------------------------
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   tile_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_data,
  output logic [ROWS*DW-1:0] out_west,
  output logic [ROWS-1:0]    out_lane_valid,
  output logic               busy,
  output logic               tile_done
);

  feeder_state_e      state_q, state_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               done_q, done_d;
  logic               accept;

  assign accept = in_valid & in_ready;

  // State register: FSM state, vector countdown, flush countdown and the
  // registered completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      flush_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. The completion pulse is registered, so it is raised on
  // the edge that leaves the tile; that lands it in the same cycle the last
  // element exits the deepest lane. An empty tile completes one cycle after
  // its start without ever leaving IDLE.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flush_d  = flush_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tile_len != '0) begin
            state_d  = ST_STREAM;
            remain_d = tile_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            if (ROWS == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FLUSH;
              flush_d = FLUSH_W'(ROWS - 1);
            end
          end
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q - FLUSH_W'(1);
        if (flush_q == FLUSH_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    in_ready  = (state_q == ST_STREAM);
    busy      = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    tile_done = done_q;
  end

  // One delay line per lane, depth r+1. Cycles without an accept inject a
  // zero bubble so invalid lanes always read zero downstream.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int LSB = lane_lsb(r, DW);

    logic [DW-1:0] laneIn;
    assign laneIn = accept ? in_data[LSB +: DW] : '0;

    skew_delay_line #(
      .DEPTH (r + 1),
      .DW    (DW)
    ) u_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .data_i  (laneIn),
      .valid_i (accept),
      .data_o  (out_west[LSB +: DW]),
      .valid_o (out_lane_valid[r])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_act_skew_feeder
// Self-checking bench for act_skew_feeder (ROWS=4, DW=8). A timestamp-based
// reference model records which vector entered the feeder in which cycle and
// derives every lane output, in_ready, busy and tile_done from that history.
// Directed scenarios pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_act_skew_feeder;

  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int LEN_W = 8;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [LEN_W-1:0]   tile_len;
  logic               in_valid;
  logic               in_ready;
  logic [ROWS*DW-1:0] in_data;
  logic [ROWS*DW-1:0] out_west;
  logic [ROWS-1:0]    out_lane_valid;
  logic               busy;
  logic               tile_done;

  int checks = 0;
  int errors = 0;

  act_skew_feeder #(
    .ROWS  (ROWS),
    .DW    (DW),
    .LEN_W (LEN_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .tile_len       (tile_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_west       (out_west),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .tile_done      (tile_done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // One cycle of stimulus: inputs change just after the rising edge and the
  // task returns at the falling edge, where outputs for that cycle are stable.
  task automatic applyStimulus(input logic s, input logic [LEN_W-1:0] len,
                               input logic v, input logic [ROWS*DW-1:0] d);
    @(posedge clk);
    #1;
    start    = s;
    tile_len = len;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  // Reference model state: the vector accepted in each cycle, whether a tile
  // is still accepting vectors, and the cycle stamps of busy end and done.
  logic [ROWS*DW-1:0] injData [int];
  int  cyc      = 0;
  bit  streaming = 1'b0;
  int  remain   = 0;
  int  busyEnd  = -1;
  int  doneAt   = -1;

  // Compare process: every falling edge out of reset, outputs are derived
  // from the accept history (lane r shows what entered r+1 cycles ago),
  // compared, then the model absorbs this cycle's inputs.
  always @(negedge clk) begin
    logic               expReady, expBusy, expDone;
    logic [ROWS*DW-1:0] expWest, entry;
    logic [ROWS-1:0]    expValid;
    if (!reset_n) begin
      injData.delete();
      streaming = 1'b0;
      remain    = 0;
      busyEnd   = -1;
      doneAt    = -1;
    end else begin
      expReady = streaming;
      expBusy  = streaming || (cyc <= busyEnd);
      expDone  = (cyc == doneAt);
      expWest  = '0;
      expValid = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (injData.exists(cyc - r - 1)) begin
          entry = injData[cyc - r - 1];
          expWest[r*DW +: DW] = entry[r*DW +: DW];
          expValid[r] = 1'b1;
        end
      end
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("tile_done", 64'(tile_done), 64'(expDone));
      checkOutput("out_lane_valid", 64'(out_lane_valid), 64'(expValid));
      checkOutput("out_west", 64'(out_west), 64'(expWest));

      if (streaming && in_valid) begin
        injData[cyc] = in_data;
        remain--;
        if (remain == 0) begin
          streaming = 1'b0;
          busyEnd   = cyc + ROWS - 1;
          doneAt    = cyc + ROWS;
        end
      end else if (!expBusy && start) begin
        if (tile_len != '0) begin
          streaming = 1'b1;
          remain    = int'(tile_len);
        end else begin
          doneAt = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // Directed tile (vectors at cycles 1..3) followed by a back-to-back tile
  // started in the tile_done cycle.
  logic [ROWS*DW-1:0] dirVec   [5]  = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                                        32'h14131211, 32'h18171615};
  logic [7:0]         lane0Exp [14] = '{8'h00, 8'h00, 8'h01, 8'h05, 8'h09, 8'h00, 8'h00,
                                        8'h00, 8'h00, 8'h11, 8'h15, 8'h00, 8'h00, 8'h00};
  logic [7:0]         lane3Exp [14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08,
                                        8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14, 8'h18};
  logic               doneExp  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    tile_len = '0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state.
    #2;
    checkOutput("rst_out_west", 64'(out_west), 64'h0);
    checkOutput("rst_lane_valid", 64'(out_lane_valid), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_tile_done", 64'(tile_done), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);

    // Directed tile of 3, then a tile of 2 started on the tile_done cycle.
    for (int c = 0; c < 14; c++) begin
      if (c == 0)                applyStimulus(1'b1, 8'd3, 1'b0, '0);
      else if (c >= 1 && c <= 3) applyStimulus(1'b0, 8'd0, 1'b1, dirVec[c-1]);
      else if (c == 7)           applyStimulus(1'b1, 8'd2, 1'b0, '0);
      else if (c == 8 || c == 9) applyStimulus(1'b0, 8'd0, 1'b1, dirVec[c-5]);
      else                       applyStimulus(1'b0, 8'd0, 1'b0, '0);
      checkOutput("dir_lane0", 64'(out_west[7:0]), 64'(lane0Exp[c]));
      checkOutput("dir_lane3", 64'(out_west[31:24]), 64'(lane3Exp[c]));
      checkOutput("dir_done", 64'(tile_done), 64'(doneExp[c]));
    end

    // Empty tile: done pulse next cycle with no busy and no data.
    applyStimulus(1'b1, 8'd0, 1'b0, '0);
    checkOutput("zero_done_early", 64'(tile_done), 64'h0);
    applyStimulus(1'b0, 8'd0, 1'b0, '0);
    checkOutput("zero_done", 64'(tile_done), 64'h1);
    checkOutput("zero_busy", 64'(busy), 64'h0);
    checkOutput("zero_valid", 64'(out_lane_valid), 64'h0);
    applyStimulus(1'b0, 8'd0, 1'b0, '0);

    // Tile with a bubble, and a start of length 9 issued mid-stream.
    applyStimulus(1'b1, 8'd3, 1'b0, '0);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[0]);
    applyStimulus(1'b1, 8'd9, 1'b0, dirVec[1]);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[1]);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[2]);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 8'd0, 1'b0, '0);

    // Reset mid-tile: outputs clear at once, nothing in flight survives.
    applyStimulus(1'b1, 8'd3, 1'b0, '0);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[0]);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[1]);
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("mid_rst_out_west", 64'(out_west), 64'h0);
    checkOutput("mid_rst_lane_valid", 64'(out_lane_valid), 64'h0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'h0);
    checkOutput("mid_rst_busy", 64'(busy), 64'h0);
    checkOutput("mid_rst_tile_done", 64'(tile_done), 64'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 8'd0, 1'b0, '0);
    applyStimulus(1'b1, 8'd2, 1'b0, '0);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[3]);
    applyStimulus(1'b0, 8'd0, 1'b1, dirVec[4]);
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 8'd0, 1'b0, '0);

    // Randomised traffic: short tiles, empty tiles, ignored starts, bubbles.
    for (int c = 0; c < 1500; c++) begin
      logic               s, v;
      logic [LEN_W-1:0]   len;
      s   = ($urandom % 6) == 0;
      len = (($urandom % 8) == 0) ? 8'd0 : LEN_W'($urandom_range(1, 7));
      v   = ($urandom % 4) != 0;
      applyStimulus(s, len, v, ROWS*DW'($urandom));
    end
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 8'd0, 1'b0, '0);

    // Maximum-length tile: exactly 255 vectors must be streamed.
    applyStimulus(1'b1, 8'd255, 1'b0, '0);
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'b0, 8'd0, ($urandom % 5) != 0, ROWS*DW'($urandom));
    end
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 8'd0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4, number of array rows (west-edge lanes), legal range 1..16.
REQ-002 Parameter DW, default 8, activation width (unsigned, matches PE west input).
REQ-003 Parameter LEN_W, default 8, width of tile length field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a tile; sampled only in IDLE.
REQ-007 tile_len  input  LEN_W  number of activation vectors in tile, latched with start.
REQ-008 in_valid  input  1  upstream vector valid.
REQ-009 in_ready  output  1  feeder accepts vector this cycle.
REQ-010 in_data  input  ROWS*DW  one activation per lane, lane r at bits [r*DW +: DW].
REQ-011 out_west  output  ROWS*DW  skewed activations to array west edge, same lane packing.
REQ-012 out_lane_valid  output  ROWS  per-lane flag: lane carries a real element.
REQ-013 busy  output  1  high in STREAM or FLUSH.
REQ-014 tile_done  output  1  one-cycle pulse at tile completion.

Function
REQ-015 FSM states IDLE, STREAM, FLUSH SHALL be encoded as a shared enum.
REQ-016 IDLE: start=1, tile_len>0 -> STREAM, remaining count loaded with tile_len.
REQ-017 IDLE: start=1, tile_len=0 -> stay IDLE, tile_done pulses the following cycle, no data emitted.
REQ-018 start outside IDLE SHALL be ignored; tile_len not re-latched.
REQ-019 in_ready SHALL be 1 only in STREAM; 0 in IDLE and FLUSH.
REQ-020 Accept = in_valid & in_ready; each accept decrements remaining count.
REQ-021 Lane r SHALL present byte r of an accepted vector exactly r+1 cycles after its accept edge (lane 0 latency 1, lane ROWS-1 latency ROWS).
REQ-022 Any cycle without accept SHALL inject zero data with lane_valid 0 at lane entry; bubbles propagate through the skew unchanged.
REQ-023 The accept that brings remaining count to 0 SHALL move STREAM -> FLUSH (ROWS>1) or STREAM -> IDLE (ROWS=1).
REQ-024 FLUSH SHALL last exactly ROWS-1 cycles, injecting zeros, then return to IDLE.
REQ-025 tile_done SHALL be high for exactly one cycle, coincident with lane ROWS-1 presenting the tile's last element.
REQ-026 A start in the same cycle tile_done is high SHALL be accepted (back-to-back tiles); skew lines SHALL not be cleared between tiles.
REQ-027 out_west lanes with lane_valid 0 SHALL read zero, so PE products contribute nothing.
REQ-028 Remaining counter SHALL not wrap; tile_len=2^LEN_W-1 SHALL stream exactly that many vectors.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, count 0, all skew registers 0, out_west 0, out_lane_valid 0, in_ready 0, busy 0, tile_done 0.
REQ-030 Reset mid-tile SHALL discard all in-flight elements; no tile_done follows.
REQ-031 Reset release SHALL be synchronised externally; first start honoured on first edge after release.

Structure
REQ-032 Shared package SHALL hold the FSM enum, ROWS/DW defaults and the lane-slice helper width constants.
REQ-033 Per-lane delay SHALL be a sub-module skew_delay_line (parameter DEPTH, data + valid), instantiated with DEPTH=r+1 for lane r.
REQ-034 Implementation SHALL not instantiate or modify the PE; feeder output drives the PE west input directly.

Verification
REQ-035 ROWS=4, start tile_len=3, vectors [1,2,3,4],[5,6,7,8],[9,10,11,12] accepted at cycles 1,2,3 -> lane0 shows 1,5,9 at 2,3,4; lane3 shows 4,8,12 at 5,6,7; tile_done at cycle 7 only.
REQ-036 Same tile with in_valid low at cycle 2 -> one zero bubble, lane_valid 0, in every lane's sequence; tile_done one cycle later.
REQ-037 start with tile_len=0 -> tile_done pulse next cycle, busy stays 0, out_lane_valid all 0.
REQ-038 Back-to-back: second start at tile_done cycle, tile_len=2 -> second tile lane0 data 1 cycle after its first accept, no gap corruption.
REQ-039 reset_n low at cycle 3 of REQ-035 -> all outputs 0 immediately, no tile_done, next start processed normally.
REQ-040 start asserted in STREAM with tile_len=9 -> ignored, original count completes.
